msg_uart_tx: RTL and testbench

MSG_UART_TX -- requirements
Module: msg_uart_tx

---
 rtl/msg_uart_tx.sv | 146 ++++++++++++++
 tb/tb_msg_uart_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_uart_tx.sv
// Message UART transmitter: walks a character ROM from index 0 to MSG_LEN-1 and
// sends each character as an 8N1 frame, with one idle-high LOAD cycle between frames.
module msg_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int MSG_LEN      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] fsm_state
);

  // Handshake: start is a level sampled at each rising edge and only acted on in
  // IDLE; done is a one-cycle completion pulse, and busy covers the whole message.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    LOAD  = 3'd4
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  ADDR_LAST = 4'(MSG_LEN - 1);

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic [3:0]  addr_n;
  logic        tx_n, busy_n, done_n;
  logic        baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rom_addr <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      rom_addr <= addr_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Outputs are registered, so each branch computes the line level for the next cycle.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    addr_n  = rom_addr;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        addr_n = '0;
        if (start) begin
          shreg_n = rom_data;
          baud_n  = '0;
          bit_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shreg[0];
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            // The bit on the line is always shreg[0]; shifting exposes the next one.
            bit_n   = bit_cnt + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
          end
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          tx_n   = 1'b1;
          if (rom_addr == ADDR_LAST) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            addr_n  = '0;
          end else begin
            addr_n  = rom_addr + 4'd1;
            state_n = LOAD;
          end
        end else begin
          baud_n = baud_cnt + 16'd1;
        end
      end
      LOAD: begin
        shreg_n = rom_data;
        baud_n  = '0;
        bit_n   = '0;
        state_n = START;
        tx_n    = 1'b0;
        busy_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_msg_uart_tx.sv
// Bench for msg_uart_tx: a message-level model predicts frames, timing, busy and done;
// a UART decoder monitor checks the serial line against the predicted frame queue.
module tb_msg_uart_tx;

  localparam int CPB     = 4;
  localparam int ML      = 10;
  localparam int FRAME   = 10 * CPB + 1;
  localparam int MSG_CYC = ML * FRAME - 1;

  // clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rom_addr, rom_addr2;
  logic [7:0] rom_data, rom_data2;
  logic       tx, busy, done, tx2, busy2, done2;
  logic [2:0] fsm_state, fsm_state2;
  logic [7:0] rom [0:15];

  assign rom_data  = rom[rom_addr];
  assign rom_data2 = 8'h41;

  msg_uart_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(ML)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .tx(tx), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  msg_uart_tx #(.CLKS_PER_BIT(2), .MSG_LEN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .tx(tx2), .busy(busy2), .done(done2), .fsm_state(fsm_state2)
  );

  // scoreboard state
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         model_end = 0;
  int         cur_first = 0;
  logic       have_msg = 1'b0;
  logic       chk_en = 1'b0;
  logic [7:0] exp_q[$];
  int         exp_t_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Reference model: a message accepted at edge e puts frame k on the line from cycle
  // e + k*FRAME, and done appears MSG_CYC cycles after the first start bit.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n !== 1'b1) begin
      model_end = cyc;
      cur_first = cyc;
      have_msg  = 1'b0;
      exp_q.delete();
      exp_t_q.delete();
    end else if (start === 1'b1 && cyc > model_end) begin
      cur_first = cyc;
      model_end = cyc + MSG_CYC;
      have_msg  = 1'b1;
      for (int k = 0; k < ML; k++) begin
        exp_q.push_back(rom[k]);
        exp_t_q.push_back(cyc + k * FRAME);
      end
    end
  end

  // per-cycle status checks against the model
  always @(negedge clk) begin : status_chk
    logic in_msg;
    if (chk_en) begin
      in_msg = (cyc >= cur_first) && (cyc < model_end);
      check("busy", busy, in_msg);
      if (!in_msg) check("tx_idle", tx, 1);
      check("done", done, have_msg && (cyc == model_end));
      check("rom_addr_range", rom_addr <= 4'(ML - 1), 1);
    end
  end

  // monitor: decode frames from tx and pop the expected queue
  initial begin : uart_mon
    logic       samp [10*CPB];
    logic [7:0] data;
    logic [7:0] ed;
    logic       aborted, shape_ok;
    int         t0, et;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        aborted = 1'b0;
        samp[0] = tx;
        for (int i = 1; i < 10 * CPB; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          samp[i] = tx;
        end
        if (!aborted) begin
          shape_ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int k = 0; k < CPB; k++)
              if (samp[b*CPB+k] !== samp[b*CPB]) shape_ok = 1'b0;
          check("frame_shape", shape_ok, 1);
          check("stop_bit", samp[9*CPB], 1);
          for (int b = 0; b < 8; b++) data[b] = samp[(b+1)*CPB];
          if (exp_q.size() == 0) begin
            fail_timeout("unexpected_frame");
          end else begin
            ed = exp_q.pop_front();
            et = exp_t_q.pop_front();
            check("frame_data", data, ed);
            check("frame_start_cycle", t0, et);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_assignment();
    logic [79:0] s;
    s = "ASSIGNMENT";
    for (int k = 0; k < 10; k++) rom[k] = s[8*(9-k) +: 8];
    for (int k = 10; k < 16; k++) rom[k] = 8'h00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (cyc >= model_end) return;
      tick();
    end
    fail_timeout("wait_idle");
  endtask

  task automatic wait_addr(input logic [3:0] a);
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rom_addr == a) return;
    end
    fail_timeout("wait_addr");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    fail_timeout("wait_done");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [9:0] f;
    load_assignment();
    repeat (3) tick();
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rom_addr", rom_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    // single message, with a start pulse ignored mid-message
    pulse_start();
    wait_addr(4'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();

    // random contents and random start pulses
    for (int m = 0; m < 4; m++) begin
      wait_idle();
      for (int k = 0; k < ML; k++) rom[k] = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 5)) tick();
      pulse_start();
      for (int p = 0; p < 3; p++) begin
        repeat ($urandom_range(1, 150)) tick();
        pulse_start();
      end
    end

    // reset during DATA of character 3, then a clean message
    wait_idle();
    load_assignment();
    pulse_start();
    wait_addr(4'd3);
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_rom_addr", rom_addr, 0);
    repeat (20) tick();
    pulse_start();
    wait_idle();

    // start held high: back-to-back messages
    tick();
    start = 1'b1;
    wait_done();
    check("hold_done_busy", busy, 0);
    @(negedge clk);
    check("hold_restart_busy", busy, 1);
    check("hold_restart_tx", tx, 0);
    wait_done();
    start = 1'b0;
    wait_idle();
    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);

    // single-character message at two clocks per bit
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    f = {1'b1, 8'h41, 1'b0};
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("m1_tx", tx2, f[j/2]);
      check("m1_busy", busy2, 1);
      check("m1_done_early", done2, 0);
      check("m1_rom_addr", rom_addr2, 0);
    end
    @(negedge clk);
    check("m1_done", done2, 1);
    check("m1_done_busy", busy2, 0);
    check("m1_done_tx", tx2, 1);
    @(negedge clk);
    check("m1_done_pulse", done2, 0);
    check("m1_idle_tx", tx2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
